// File: rtl/acq_sequencer_if.sv
// Bundle of the acquisition sequencer control/status signals.
// master: the sequencer itself; slave: the Top-level glue/ADC/AGC side.
interface acq_sequencer_if;
  logic        start;
  logic        stop;
  logic [9:0]  ctrlword_in;
  logic [11:0] agc_level;
  logic        agc_update;
  logic        agc_busy;
  logic        adc_valid;
  logic        fifo_full;
  logic [9:0]  adc_ctrlword;
  logic        adc_ldctrl;
  logic        adc_enable;
  logic [11:0] agc_data;
  logic        agc_load;
  logic        fifo_clr;
  logic [2:0]  state;
  logic        overflow;
  logic        fault;

  modport master (
    input  start, stop, ctrlword_in, agc_level, agc_update, agc_busy, adc_valid, fifo_full,
    output adc_ctrlword, adc_ldctrl, adc_enable, agc_data, agc_load, fifo_clr, state,
           overflow, fault
  );

  modport slave (
    output start, stop, ctrlword_in, agc_level, agc_update, agc_busy, adc_valid, fifo_full,
    input  adc_ctrlword, adc_ldctrl, adc_enable, agc_data, agc_load, fifo_clr, state,
           overflow, fault
  );
endinterface

// File: rtl/acq_sequencer.sv
// I/Q ADC acquisition sequencer: FIFO clear, ADC config load, AGC write, settle, run.
// Optional RUN watchdog enabled by defining SEQ_WATCHDOG_EN.
module acq_sequencer #(
  parameter int unsigned CLR_CYCLES  = 4,
  parameter int unsigned LD_DELAY    = 100,
  parameter int unsigned EN_DELAY    = 900,
  parameter logic [11:0] AGC_RESET   = 12'h333,
  parameter int unsigned CNT_W       = 20,
  parameter int unsigned WDOG_CYCLES = 4096
) (
  input  logic            clk,
  input  logic            arstn,
  acq_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLR    = 3'd1,
    S_LOAD   = 3'd2,
    S_AGC    = 3'd3,
    S_SETTLE = 3'd4,
    S_RUN    = 3'd5
  } state_t;

  localparam longint unsigned LP_CNT_LIM = 64'd1 << CNT_W;

  // Every delay must fit the shared counter, which never wraps.
  if (CLR_CYCLES == 0 || LD_DELAY == 0 || EN_DELAY == 0 || WDOG_CYCLES == 0 ||
      CLR_CYCLES >= LP_CNT_LIM || LD_DELAY >= LP_CNT_LIM ||
      EN_DELAY >= LP_CNT_LIM || WDOG_CYCLES >= LP_CNT_LIM) begin : g_bad_param
    $error("acq_sequencer: delay parameter out of range for CNT_W");
  end

  state_t             r_state, w_next;
  logic [CNT_W-1:0]   r_cnt, w_cnt_n;
  logic [9:0]         r_ctrlword, w_ctrlword_n;
  logic [11:0]        r_agc_data, w_agc_data_n;
  logic [11:0]        r_pend_val, w_pend_val_n;
  logic               r_pend, w_pend_n;
  logic               r_ldctrl, w_ldctrl_n;
  logic               r_enable, w_enable_n;
  logic               r_agc_load, w_agc_load_n;
  logic               r_fifo_clr, w_fifo_clr_n;
  logic               r_overflow, w_overflow_n;
  logic               r_fault, w_fault_n;
  logic               w_wdog_trip, w_abort, w_start_acc, w_busy_eff;

`ifdef SEQ_WATCHDOG_EN
  assign w_wdog_trip = (r_state == S_RUN) && !bus.adc_valid &&
                       (r_cnt == CNT_W'(WDOG_CYCLES - 1));
`else
  assign w_wdog_trip = 1'b0;
`endif

  assign w_abort     = (r_state != S_IDLE) && (bus.stop || w_wdog_trip);
  assign w_start_acc = (r_state == S_IDLE) && bus.start && !bus.stop;
  // A load we just issued counts as busy until the SPI master reports it.
  assign w_busy_eff  = bus.agc_busy || r_agc_load;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_abort) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:   if (w_start_acc) w_next = S_CLR;
        S_CLR:    if (r_cnt == CNT_W'(CLR_CYCLES - 1)) w_next = S_LOAD;
        S_LOAD:   if (r_cnt == CNT_W'(LD_DELAY - 1)) w_next = S_AGC;
        S_AGC:    if (r_cnt != '0 && !bus.agc_busy) w_next = S_SETTLE;
        S_SETTLE: if (r_cnt == CNT_W'(EN_DELAY - 1)) w_next = S_RUN;
        S_RUN:    w_next = S_RUN;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_cnt_n      = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
    w_fifo_clr_n = (w_next == S_CLR);
    w_ldctrl_n   = (w_next == S_LOAD) && (r_state != S_LOAD);
    w_enable_n   = (w_next == S_RUN);
    w_ctrlword_n = r_ctrlword;
    w_agc_data_n = r_agc_data;
    w_agc_load_n = 1'b0;
    w_pend_n     = r_pend;
    w_pend_val_n = r_pend_val;
    w_overflow_n = r_overflow;
    w_fault_n    = r_fault;

    if (w_next != r_state) w_cnt_n = '0;
`ifdef SEQ_WATCHDOG_EN
    else if (r_state == S_RUN && bus.adc_valid) w_cnt_n = '0;
`endif

    if (w_start_acc) begin
      w_ctrlword_n = bus.ctrlword_in;
      w_agc_data_n = bus.agc_level;
      w_pend_n     = 1'b0;
      w_overflow_n = 1'b0;
      w_fault_n    = 1'b0;
    end

    if (w_next == S_AGC && r_state != S_AGC) w_agc_load_n = 1'b1;

    // Runtime AGC: agc_data only moves together with the load strobe, never under busy.
    if (r_state == S_RUN && !w_abort) begin
      if (bus.agc_update) begin
        if (!w_busy_eff) begin
          w_agc_data_n = bus.agc_level;
          w_agc_load_n = 1'b1;
          w_pend_n     = 1'b0;
        end else begin
          w_pend_n     = 1'b1;
          w_pend_val_n = bus.agc_level;
        end
      end else if (r_pend && !w_busy_eff) begin
        w_agc_data_n = r_pend_val;
        w_agc_load_n = 1'b1;
        w_pend_n     = 1'b0;
      end
    end

    if (w_abort) w_pend_n = 1'b0;
    if (r_state == S_RUN && bus.adc_valid && bus.fifo_full) w_overflow_n = 1'b1;
    if (w_wdog_trip) w_fault_n = 1'b1;
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_cnt      <= '0;
      r_ctrlword <= 10'b0001100011;
      r_agc_data <= AGC_RESET;
      r_pend_val <= AGC_RESET;
      r_pend     <= 1'b0;
      r_ldctrl   <= 1'b0;
      r_enable   <= 1'b0;
      r_agc_load <= 1'b0;
      r_fifo_clr <= 1'b0;
      r_overflow <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_n;
      r_ctrlword <= w_ctrlword_n;
      r_agc_data <= w_agc_data_n;
      r_pend_val <= w_pend_val_n;
      r_pend     <= w_pend_n;
      r_ldctrl   <= w_ldctrl_n;
      r_enable   <= w_enable_n;
      r_agc_load <= w_agc_load_n;
      r_fifo_clr <= w_fifo_clr_n;
      r_overflow <= w_overflow_n;
      r_fault    <= w_fault_n;
    end
  end

  assign bus.adc_ctrlword = r_ctrlword;
  assign bus.adc_ldctrl   = r_ldctrl;
  assign bus.adc_enable   = r_enable;
  assign bus.agc_data     = r_agc_data;
  assign bus.agc_load     = r_agc_load;
  assign bus.fifo_clr     = r_fifo_clr;
  assign bus.state        = r_state;
  assign bus.overflow     = r_overflow;
  assign bus.fault        = r_fault;

endmodule

// File: tb/tb_acq_sequencer.sv
// Directed bench for acq_sequencer with short delays (CLR 4, LOAD 4, SETTLE 8, WDOG 64).
module tb_acq_sequencer;
  logic clk;
  logic arstn;
  int unsigned n_checks;
  int unsigned n_errors;

  acq_sequencer_if u_if ();

  acq_sequencer #(
    .CLR_CYCLES (4),
    .LD_DELAY   (4),
    .EN_DELAY   (8),
    .AGC_RESET  (12'h333),
    .CNT_W      (20),
    .WDOG_CYCLES(64)
  ) u_dut (
    .clk  (clk),
    .arstn(arstn),
    .bus  (u_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic clear_inputs();
    u_if.start       = 1'b0;
    u_if.stop        = 1'b0;
    u_if.agc_update  = 1'b0;
    u_if.agc_busy    = 1'b0;
    u_if.adc_valid   = 1'b0;
    u_if.fifo_full   = 1'b0;
  endtask

  // Pulse start, then wait (bounded) until RUN is reached with agc_busy held low.
  task automatic run_to_run(input logic [9:0] cw, input logic [11:0] lvl);
    int unsigned waited;
    u_if.ctrlword_in = cw;
    u_if.agc_level   = lvl;
    u_if.start       = 1'b1;
    @(negedge clk);
    u_if.start = 1'b0;
    waited = 0;
    while (u_if.state != 3'd5 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    chk("run_reached", {29'd0, u_if.state}, 32'd5);
  endtask

  initial begin
    int unsigned loads;
    int          load_c;
    n_checks = 0;
    n_errors = 0;
    arstn = 1'b0;
    clear_inputs();
    u_if.ctrlword_in = 10'h0;
    u_if.agc_level   = 12'h0;
    repeat (3) @(negedge clk);

    chk("rst_state",    {29'd0, u_if.state}, 32'd0);
    chk("rst_ctrlword", {22'd0, u_if.adc_ctrlword}, 32'h063);
    chk("rst_agc_data", {20'd0, u_if.agc_data}, 32'h333);
    chk("rst_strobes",  {27'd0, u_if.adc_ldctrl, u_if.adc_enable, u_if.agc_load,
                         u_if.fifo_clr, u_if.overflow | u_if.fault}, 32'd0);
    arstn = 1'b1;
    @(negedge clk);

    // Main bring-up: start at c0, busy c10..c25.
    loads  = 0;
    load_c = -1;
    for (int c = 0; c <= 40; c++) begin
      if (u_if.agc_load) begin
        loads++;
        load_c = c;
      end
      if (c == 1)  chk("c1_state_clr", {29'd0, u_if.state}, 32'd1);
      if (c == 1)  chk("c1_fifo_clr", {31'd0, u_if.fifo_clr}, 32'd1);
      if (c == 4)  chk("c4_fifo_clr", {31'd0, u_if.fifo_clr}, 32'd1);
      if (c == 5)  chk("c5_fifo_clr_off", {31'd0, u_if.fifo_clr}, 32'd0);
      if (c == 5)  chk("c5_ldctrl", {31'd0, u_if.adc_ldctrl}, 32'd1);
      if (c == 5)  chk("c5_ctrlword", {22'd0, u_if.adc_ctrlword}, 32'h155);
      if (c == 6)  chk("c6_ldctrl_off", {31'd0, u_if.adc_ldctrl}, 32'd0);
      if (c == 9)  chk("c9_state_agc", {29'd0, u_if.state}, 32'd3);
      if (c == 9)  chk("c9_agc_data", {20'd0, u_if.agc_data}, 32'h7FF);
      if (c == 33) chk("c33_enable_off", {31'd0, u_if.adc_enable}, 32'd0);
      if (c == 35) chk("c35_enable_on", {31'd0, u_if.adc_enable}, 32'd1);
      if (c == 40) chk("c40_state_run", {29'd0, u_if.state}, 32'd5);
      u_if.start       = (c == 0);
      u_if.ctrlword_in = 10'h155;
      u_if.agc_level   = 12'h7FF;
      u_if.agc_busy    = (c >= 10 && c <= 25);
      @(negedge clk);
    end
    chk("bringup_load_count", loads, 32'd1);
    chk("bringup_load_cycle", load_c, 32'd9);

    // Two AGC updates while busy: one load, one cycle after busy falls, with the last level.
    loads  = 0;
    load_c = -1;
    for (int k = 0; k <= 9; k++) begin
      if (u_if.agc_load) begin
        loads++;
        load_c = k;
      end
      if (k == 6) chk("agc_data_held_busy", {20'd0, u_if.agc_data}, 32'h7FF);
      if (k == 7) chk("agc_data_pending", {20'd0, u_if.agc_data}, 32'h456);
      u_if.agc_busy   = (k <= 5);
      u_if.agc_update = (k == 1 || k == 3);
      u_if.agc_level  = (k == 1) ? 12'h123 : 12'h456;
      @(negedge clk);
    end
    u_if.agc_update = 1'b0;
    chk("agc_upd_load_count", loads, 32'd1);
    chk("agc_upd_load_cycle", load_c, 32'd7);

    // Sticky overflow through stop, cleared by the next start.
    u_if.adc_valid = 1'b1;
    u_if.fifo_full = 1'b1;
    @(negedge clk);
    u_if.adc_valid = 1'b0;
    u_if.fifo_full = 1'b0;
    chk("overflow_set", {31'd0, u_if.overflow}, 32'd1);
    u_if.stop = 1'b1;
    @(negedge clk);
    u_if.stop = 1'b0;
    chk("stop_state_idle", {29'd0, u_if.state}, 32'd0);
    chk("stop_enable_off", {31'd0, u_if.adc_enable}, 32'd0);
    chk("overflow_after_stop", {31'd0, u_if.overflow}, 32'd1);
    run_to_run(10'h2AA, 12'h0F0);
    chk("overflow_cleared", {31'd0, u_if.overflow}, 32'd0);
    chk("restart_ctrlword", {22'd0, u_if.adc_ctrlword}, 32'h2AA);

    // Watchdog: no adc_valid for 64 cycles after RUN entry.
    repeat (63) @(negedge clk);
    chk("wdog_pre_state", {29'd0, u_if.state}, 32'd5);
    @(negedge clk);
`ifdef SEQ_WATCHDOG_EN
    chk("wdog_fault", {31'd0, u_if.fault}, 32'd1);
    chk("wdog_state_idle", {29'd0, u_if.state}, 32'd0);
`else
    chk("nowdog_fault", {31'd0, u_if.fault}, 32'd0);
    chk("nowdog_state_run", {29'd0, u_if.state}, 32'd5);
`endif

    // start and stop together in RUN: stop wins, no new sequence.
    if (u_if.state != 3'd5) run_to_run(10'h155, 12'h0F0);
    u_if.start = 1'b1;
    u_if.stop  = 1'b1;
    @(negedge clk);
    u_if.start = 1'b0;
    u_if.stop  = 1'b0;
    chk("startstop_idle", {29'd0, u_if.state}, 32'd0);
    chk("startstop_enable", {31'd0, u_if.adc_enable}, 32'd0);
    @(negedge clk);
    chk("startstop_no_seq", {29'd0, u_if.state}, 32'd0);
    chk("startstop_no_clr", {31'd0, u_if.fifo_clr}, 32'd0);

    // Asynchronous reset mid-RUN with non-default outputs.
    run_to_run(10'h2AA, 12'h0F0);
    u_if.adc_valid = 1'b1;
    u_if.fifo_full = 1'b1;
    @(negedge clk);
    u_if.adc_valid = 1'b0;
    u_if.fifo_full = 1'b0;
    arstn = 1'b0;
    @(negedge clk);
    chk("midrst_state", {29'd0, u_if.state}, 32'd0);
    chk("midrst_ctrlword", {22'd0, u_if.adc_ctrlword}, 32'h063);
    chk("midrst_agc_data", {20'd0, u_if.agc_data}, 32'h333);
    chk("midrst_flags", {27'd0, u_if.adc_enable, u_if.overflow, u_if.fault,
                         u_if.agc_load, u_if.fifo_clr}, 32'd0);
    arstn = 1'b1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
